// File: rtl/switch_capture.sv
// Board switch/button capture: synchronize, debounce, edge pulses, and
// serialize every debounced change into a small valid/ready event FIFO.
module switch_capture #(
  parameter int unsigned WIDTH          = 8,
  parameter real         CLK_FREQUENCY  = 12.0e6,
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter bit          ACTIVE_LOW     = 1'b1,
  parameter int unsigned FIFO_DEPTH     = 4,
  localparam int unsigned IDXW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDXW:0]    evt_data,
  output logic             evt_overflow,
  input  logic             ovf_clr
);

  localparam int unsigned TICK_DIV = int'(CLK_FREQUENCY * 1.0e-3);
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PTRW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW     = PTRW + 1;
  localparam int unsigned DBW      = 8;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DBW-1:0]    DB_LAST   = DBW'(DEBOUNCE_TICKS - 1);
  localparam logic [WIDTH-1:0]  RAW_IDLE  = {WIDTH{ACTIVE_LOW}};
  localparam logic [CNTW-1:0]   FIFO_FULL = CNTW'(FIFO_DEPTH);

  // Synchronizer
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] s_c;

  // Prescaler
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_c;

  // Debounce
  logic [DBW-1:0]   db_cnt_q [WIDTH];
  logic [DBW-1:0]   db_cnt_d [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] toggle_c;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Pending / serializer
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] push_clr_c;
  logic [IDXW-1:0]  sel_idx_c;
  logic             push_c;
  logic [IDXW:0]    push_data_c;
  logic             ovf_q, ovf_d;
  logic             ovf_set_c;

  // FIFO
  logic [IDXW:0]    fifo_q [FIFO_DEPTH];
  logic [IDXW:0]    fifo_d [FIFO_DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             full_c;
  logic             empty_c;
  logic             pop_c;

  // Two-flop synchronizer; polarity normalized so 1 = asserted
  always_comb begin
    sync1_d = sw_in;
    sync2_d = sync1_q;
    s_c     = ACTIVE_LOW ? ~sync2_q : sync2_q;
  end

  // Free-running 1 ms tick
  always_comb begin
    tick_c     = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Per-bit debounce: count stable ticks while the input differs from the level
  always_comb begin
    level_d  = level_q;
    toggle_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (s_c[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (tick_c) begin
        if (db_cnt_q[i] == DB_LAST) begin
          toggle_c[i] = 1'b1;
          level_d[i]  = ~level_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
        end
      end
    end
    rise_d = toggle_c & level_d;
    fall_d = toggle_c & ~level_d;
  end

  // Lowest pending index wins the single push slot each cycle
  always_comb begin
    sel_idx_c = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_idx_c = IDXW'(i);
      end
    end
    full_c      = (count_q == FIFO_FULL);
    empty_c     = (count_q == '0);
    pop_c       = !empty_c && evt_ready;
    push_c      = (|pend_q) && !full_c;
    push_data_c = {level_q[sel_idx_c], sel_idx_c};
    push_clr_c  = '0;
    if (push_c) begin
      push_clr_c[sel_idx_c] = 1'b1;
    end
  end

  // A change on a bit whose previous event is still pending loses that event
  always_comb begin
    pend_d    = (pend_q & ~push_clr_c) | toggle_c;
    ovf_set_c = |(toggle_c & pend_q & ~push_clr_c);
    ovf_d     = ovf_set_c | (ovf_q & ~ovf_clr);
  end

  always_comb begin
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      fifo_d[i] = fifo_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNTW'(push_c) - CNTW'(pop_c);
    if (push_c) begin
      fifo_d[wr_ptr_q] = push_data_c;
      wr_ptr_d         = wr_ptr_q + PTRW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTRW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= RAW_IDLE;
      sync2_q    <= RAW_IDLE;
      tick_cnt_q <= '0;
      level_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        db_cnt_q[i] <= '0;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  // Head entry falls through; data forced to zero while empty
  assign sw_level     = level_q;
  assign sw_rise      = rise_q;
  assign sw_fall      = fall_q;
  assign evt_overflow = ovf_q;
  assign evt_valid    = !empty_c;
  assign evt_data     = empty_c ? '0 : fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_switch_capture.sv
// Scoreboard bench for switch_capture: debounce timing, glitch rejection,
// event ordering under back-pressure, overflow and back-to-back toggles.
module tb_switch_capture;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDXW  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_level;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             evt_valid;
  logic             evt_ready;
  logic [IDXW:0]    evt_data;
  logic             evt_overflow;
  logic             ovf_clr;

  int checks = 0;
  int errors = 0;
  logic [IDXW:0] exp_q [$];

  switch_capture #(
    .WIDTH(WIDTH),
    .CLK_FREQUENCY(1.0e4),
    .DEBOUNCE_TICKS(3),
    .ACTIVE_LOW(1'b1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_in(sw_in),
    .sw_level(sw_level),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data(evt_data),
    .evt_overflow(evt_overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n     = 1'b0;
    sw_in     = 8'hFF;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sw_level, sw_rise, sw_fall} !== 24'h0) begin
      errors++;
      $display("FAIL reset_vectors: got %h required 000000", {sw_level, sw_rise, sw_fall});
    end
    checks++;
    if ({evt_valid, evt_overflow, evt_data} !== 6'h0) begin
      errors++;
      $display("FAIL reset_evt: got %b required 000000", {evt_valid, evt_overflow, evt_data});
    end
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      checks++;
      if ({sw_level, sw_rise, sw_fall, evt_valid, evt_overflow} !== 26'h0) begin
        errors++;
        $display("FAIL idle cycle %0d: got %h required 0", c,
                 {sw_level, sw_rise, sw_fall, evt_valid, evt_overflow});
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    int seen;
    @(negedge clk);
    sw_in[1] = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sw_level, sw_rise, sw_fall, evt_valid, evt_overflow, evt_data} !== 30'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h required 0",
               {sw_level, sw_rise, sw_fall, evt_valid, evt_overflow, evt_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (sw_level[1]) begin
        seen = k;
        break;
      end
    end
    checks++;
    if (seen < 23 || seen > 33) begin
      errors++;
      $display("FAIL mid_reset_restart: level after %0d cycles required 23..33", seen);
    end
    sw_in = 8'hFF;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_single_press();
    int seen;
    logic [IDXW:0] exp;
    @(negedge clk);
    sw_in[2] = 1'b0;
    exp_q.push_back({1'b1, 3'd2});
    seen = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (sw_level[2]) begin
        seen = k;
        break;
      end
    end
    checks++;
    if (seen < 23 || seen > 33) begin
      errors++;
      $display("FAIL press_latency: level after %0d cycles required 23..33", seen);
    end
    checks++;
    if ({sw_level, sw_rise, sw_fall, evt_valid} !== {8'h04, 8'h04, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL press_edge: got %h required %h", {sw_level, sw_rise, sw_fall, evt_valid},
               {8'h04, 8'h04, 8'h00, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({sw_rise, evt_valid} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL press_pulse_valid: got %h required %h", {sw_rise, evt_valid}, {8'h00, 1'b1});
    end
    exp = exp_q.pop_front();
    checks++;
    if (evt_data !== exp) begin
      errors++;
      $display("FAIL press_data: got %h required %h", evt_data, exp);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL press_pop: evt_valid got %b required 0", evt_valid);
    end
    sw_in[2] = 1'b1;
    exp_q.push_back({1'b0, 3'd2});
    seen = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!sw_level[2]) begin
        seen = k;
        break;
      end
    end
    checks++;
    if (seen == 0 || sw_fall !== 8'h04) begin
      errors++;
      $display("FAIL release_fall: sw_fall got %h required 04 (cycles %0d)", sw_fall, seen);
    end
    evt_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (evt_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if (evt_data !== exp) begin
          errors++;
          $display("FAIL release_data: got %h required %h", evt_data, exp);
        end
      end
      @(negedge clk);
    end
    evt_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL release_drain: %0d events missing required 0", exp_q.size());
    end
  endtask

  task automatic test_glitch();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      sw_in[5] = !((c < 8) || (c >= 30 && c < 42));
      checks++;
      if ({sw_level, sw_rise, sw_fall, evt_valid} !== 25'h0) begin
        errors++;
        $display("FAIL glitch cycle %0d: got %h required 0", c,
                 {sw_level, sw_rise, sw_fall, evt_valid});
      end
    end
  endtask

  task automatic test_all_at_once();
    int seen;
    logic [IDXW:0] exp;
    evt_ready = 1'b0;
    @(negedge clk);
    sw_in = 8'h00;
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 3'(i)});
    seen = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (sw_level != 8'h00) begin
        seen = k;
        break;
      end
    end
    checks++;
    if (seen == 0 || sw_level !== 8'hFF || sw_rise !== 8'hFF) begin
      errors++;
      $display("FAIL all_edge: level %h rise %h required FF FF", sw_level, sw_rise);
    end
    repeat (10) @(negedge clk);
    checks++;
    if ({evt_valid, evt_overflow} !== 2'b10) begin
      errors++;
      $display("FAIL all_backpressure: valid/ovf got %b required 10", {evt_valid, evt_overflow});
    end
    evt_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      if (evt_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if (evt_data !== exp) begin
          errors++;
          $display("FAIL all_order: got %h required %h", evt_data, exp);
        end
      end
      @(negedge clk);
    end
    evt_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || evt_valid !== 1'b0 || evt_overflow !== 1'b0) begin
      errors++;
      $display("FAIL all_drain: left %0d valid %b ovf %b required 0 0 0",
               exp_q.size(), evt_valid, evt_overflow);
    end
  endtask

  task automatic test_overflow();
    logic [IDXW:0] exp;
    evt_ready = 1'b0;
    @(negedge clk);
    sw_in = 8'h8F;
    exp_q.push_back({1'b0, 3'd0});
    exp_q.push_back({1'b0, 3'd1});
    exp_q.push_back({1'b0, 3'd2});
    exp_q.push_back({1'b0, 3'd3});
    exp_q.push_back({1'b0, 3'd7});
    for (int k = 0; k < 60 && sw_level != 8'h70; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if ({sw_level, evt_overflow} !== {8'h70, 1'b0}) begin
      errors++;
      $display("FAIL ovf_pre: level/ovf got %h required %h", {sw_level, evt_overflow}, {8'h70, 1'b0});
    end
    sw_in[7] = 1'b0;
    for (int k = 0; k < 60 && !sw_level[7]; k++) @(negedge clk);
    checks++;
    if ({sw_level[7], evt_overflow} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_set: level7/ovf got %b required 11", {sw_level[7], evt_overflow});
    end
    sw_in[7] = 1'b1;
    for (int k = 0; k < 60 && sw_level[7]; k++) @(negedge clk);
    evt_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      if (evt_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if (evt_data !== exp) begin
          errors++;
          $display("FAIL ovf_order: got %h required %h", evt_data, exp);
        end
      end
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || evt_valid !== 1'b0 || evt_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: left %0d valid %b ovf %b required 0 0 1",
               exp_q.size(), evt_valid, evt_overflow);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (evt_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b required 0", evt_overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [IDXW:0] exp;
    evt_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      sw_in[0] = ~sw_in[0];
      exp_q.push_back({~sw_in[0], 3'd0});
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (evt_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_extra: unexpected event %h required none", evt_data);
          end else begin
            exp = exp_q.pop_front();
            if (evt_data !== exp) begin
              errors++;
              $display("FAIL b2b_data toggle %0d: got %h required %h", t, evt_data, exp);
            end
          end
        end
      end
    end
    evt_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || evt_overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: left %0d ovf %b required 0 0", exp_q.size(), evt_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_reset_mid_debounce();
    test_single_press();
    test_glitch();
    test_all_at_once();
    test_overflow();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
